// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-entry byte FIFO in front of a UART transmitter.
// Bytes are launched one at a time through the tx_start / tx_busy handshake.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_50MHZ,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_ARM   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ZERO = '0;

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wp_r;
    logic [ADDR_W-1:0] rp_r;
    logic [ADDR_W:0]   count_r;
    logic              overflow_r;
    logic              tx_start_r;
    logic [7:0]        tx_data_r;
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              push_s;
    logic              reject_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == CNT_ZERO);

    // Push/pop/reject decode; flush suppresses all three in its cycle.
    always_comb begin
        pop_s    = 1'b0;
        push_s   = 1'b0;
        reject_s = 1'b0;
        if (!flush) begin
            pop_s    = (state_r == S_IDLE) && !empty_s && !tx_busy;
            push_s   = wr_en && (!full_s || pop_s);
            reject_s = wr_en && full_s && !pop_s;
        end else begin
            pop_s    = 1'b0;
            push_s   = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Launch sequencer next state; IDLE leaves only on a pop.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pop_s) state_nxt_s = S_START;
                else       state_nxt_s = S_IDLE;
            end
            S_START: state_nxt_s = S_ARM;
            S_ARM: begin
                if (tx_busy) state_nxt_s = S_DRAIN;
                else         state_nxt_s = S_ARM;
            end
            S_DRAIN: begin
                if (!tx_busy) state_nxt_s = S_IDLE;
                else          state_nxt_s = S_DRAIN;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            wp_r    <= '0;
            rp_r    <= '0;
            count_r <= '0;
        end else if (flush) begin
            wp_r    <= '0;
            rp_r    <= '0;
            count_r <= '0;
        end else begin
            if (push_s) wp_r <= wp_r + 1'b1;
            if (pop_s)  rp_r <= rp_r + 1'b1;
            if (push_s && !pop_s)      count_r <= count_r + 1'b1;
            else if (pop_s && !push_s) count_r <= count_r - 1'b1;
            else                       count_r <= count_r;
        end
    end

    // Storage array; contents deliberately left unreset.
    always_ff @(posedge clk_50MHZ) begin
        if (push_s) mem_r[wp_r] <= wr_data;
    end

    // Sticky overflow: a rejected push beats a simultaneous clear.
    always_ff @(posedge clk_50MHZ or negedge rst_n) begin
        if (!rst_n)        overflow_r <= 1'b0;
        else if (reject_s) overflow_r <= 1'b1;
        else if (ovf_clr)  overflow_r <= 1'b0;
        else               overflow_r <= overflow_r;
    end

    // Launch state, start pulse and held transmit byte.
    always_ff @(posedge clk_50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            tx_start_r <= pop_s;
            if (pop_s) tx_data_r <= mem_r[rp_r];
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;

endmodule
